// File: rtl/clk_ratio_monitor.sv
// Receive-side ratio checker for a divided clock. It measures each clk_in half-period in clk
// cycles and locks after LOCK_CNT in-tolerance results. It reports mismatches and stuck clocks.
module clk_ratio_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned EXP_HALF    = 4,
    parameter int unsigned TOL         = 0,
    parameter int unsigned LOCK_CNT    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             enable,
    input  logic             clear_err,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count
);
    localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   EXP_X   = (CNT_W+1)'(EXP_HALF);
    localparam logic [CNT_W:0]   TOL_X   = (CNT_W+1)'(TOL);
    localparam logic [MC_W-1:0]  LOCK_MC = MC_W'(LOCK_CNT);
    localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_MEASURE,
        S_LOCKED
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_q;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_half_period;
    logic [MC_W-1:0]        r_mcnt;
    logic                   r_to_fired;
    logic                   r_period_valid;
    logic                   r_locked;
    logic                   r_err;
    logic [7:0]             r_err_count;

    logic                   w_edge;
    logic [CNT_W:0]         w_cnt_x;
    logic [CNT_W:0]         w_dev;
    logic                   w_match;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [MC_W-1:0]        w_mcnt_nxt;
    logic [7:0]             w_err_inc;
    logic                   w_timeout;
    logic                   w_err_evt;

    always_comb begin
        w_edge     = r_sync[SYNC_STAGES-1] ^ r_sync_q;
        // Deviation is taken one bit wider than the counter so it never wraps.
        w_cnt_x    = {1'b0, r_cnt};
        w_dev      = (w_cnt_x >= EXP_X) ? (w_cnt_x - EXP_X) : (EXP_X - w_cnt_x);
        w_match    = (w_dev <= TOL_X);
        w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
        w_mcnt_nxt = r_mcnt + MC_ONE;
        w_err_inc  = (r_err_count == 8'hFF) ? r_err_count : (r_err_count + 8'd1);
        // A stuck clock reports once; an edge re-arms the timeout.
        w_timeout  = !w_edge && (r_cnt == CNT_MAX) && !r_to_fired;
        w_err_evt  = enable && (r_state != S_IDLE) &&
                     (w_timeout || ((r_state == S_LOCKED) && w_edge && !w_match));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_sync         <= '0;
            r_sync_q       <= 1'b0;
            r_cnt          <= '0;
            r_half_period  <= '0;
            r_mcnt         <= '0;
            r_to_fired     <= 1'b0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_err          <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_sync         <= {r_sync[SYNC_STAGES-2:0], clk_in};
            r_sync_q       <= r_sync[SYNC_STAGES-1];
            r_period_valid <= 1'b0;
            r_err          <= w_err_evt;

            if (clear_err) begin
                r_err_count <= '0;
            end else if (w_err_evt) begin
                r_err_count <= w_err_inc;
            end

            if (!enable) begin
                r_state    <= S_IDLE;
                r_locked   <= 1'b0;
                r_cnt      <= '0;
                r_to_fired <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt      <= '0;
                        r_to_fired <= 1'b0;
                        r_state    <= S_ACQUIRE;
                    end
                    default: begin
                        r_cnt <= w_edge ? CNT_ONE : w_cnt_inc;
                        if (w_edge) begin
                            r_to_fired <= 1'b0;
                            if (r_state == S_ACQUIRE) begin
                                r_state <= S_MEASURE;
                                r_mcnt  <= '0;
                            end else begin
                                r_half_period  <= r_cnt;
                                r_period_valid <= 1'b1;
                                if (r_state == S_MEASURE) begin
                                    if (!w_match) begin
                                        r_mcnt <= '0;
                                    end else if (w_mcnt_nxt == LOCK_MC) begin
                                        r_state  <= S_LOCKED;
                                        r_locked <= 1'b1;
                                        r_mcnt   <= '0;
                                    end else begin
                                        r_mcnt <= w_mcnt_nxt;
                                    end
                                end else if (!w_match) begin
                                    r_state  <= S_MEASURE;
                                    r_locked <= 1'b0;
                                    r_mcnt   <= '0;
                                end
                            end
                        end else if (w_timeout) begin
                            r_to_fired <= 1'b1;
                            r_locked   <= 1'b0;
                            r_state    <= S_ACQUIRE;
                        end
                    end
                endcase
            end
        end
    end

    assign half_period  = r_half_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign err          = r_err;
    assign err_count    = r_err_count;

endmodule
